alu_vec_issue: RTL and testbench
================================

Name: alu_vec_issue

Overview:
- Issue/sequencing side of the 32-bit ALU: accepts one vector ALU command per handshake and walks its elements.
- For each element, reads operands from the vector register file (VRF), drives the ALU's ctl/a/b, and captures the ALU result and zero flag.
- Writes each result back to the VRF and signals completion with a one-cycle done pulse.
- Sits between the vector decode stage and the ALU/VRF pair.

Parameters:
ELEMS, 8, maximum elements per vector register
AW, 3, element index width (log2 ELEMS)
DW, 32, element data width; must match the ALU width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  block can accept a command
cmd_ctl  in  4  ALU op code, passed unchanged to alu_ctl
cmd_vlen  in  AW+1  element count; 0 allowed; values above ELEMS clamp to ELEMS
cmd_vs1  in  5  source register for operand a
cmd_vs2  in  5  source register for operand b
cmd_vd  in  5  destination register
cmd_scalar_en  in  1  1: operand b = cmd_scalar for every element
cmd_scalar  in  DW  scalar operand b
rd_reg1, rd_reg2  out  5 each  VRF read register selects
rd_idx  out  AW  VRF read element index, shared by both read ports
rd_data1, rd_data2  in  DW each  VRF read data, valid one cycle after the address
alu_ctl  out  4  to ALU ctl
alu_a, alu_b  out  DW each  to ALU operands
alu_out  in  DW  ALU result (combinational)
alu_zero  in  1  ALU zero flag
wr_en  out  1  VRF write strobe
wr_reg  out  5  VRF write register
wr_idx  out  AW  VRF write element index
wr_data  out  DW  VRF write data
busy  out  1  command in progress
done  out  1  one-cycle completion pulse
all_zero  out  1  1 if every written element was zero; valid while done=1, held until the next accept

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - cmd_ready=1 (combinational, asserted while in IDLE).
  - busy=0, done=0, all_zero=0, wr_en=0.
  - All address, index and data outputs 0.
  - Latched command fields cleared.
  - Reset mid-command abandons it silently: no further writes and no done pulse.
- Accept: cmd_valid & cmd_ready at a rising edge. All cmd_* fields are latched; inputs are ignored afterwards. cmd_ready=0 in every state other than IDLE.
- States:
  - IDLE -> RUN on accept with clamped vlen>0.
  - IDLE -> DONE on accept with vlen=0. No reads, no writes; all_zero=1.
  - RUN: each cycle presents rd_idx=i for i=0..vlen-1. Moves to DRAIN after issuing index vlen-1.
  - DRAIN: one cycle that completes the final element write. Moves to DONE.
  - DONE: done=1 for exactly one cycle. Moves to IDLE.
- Pipeline:
  - The read of index i is issued in cycle k.
  - In cycle k+1: alu_a=rd_data1, alu_b=(scalar_en ? latched scalar : rd_data2), alu_ctl=latched ctl.
  - Also in cycle k+1: wr_en=1, wr_reg=vd, wr_idx=i, wr_data=alu_out.
  - Reads and writes overlap, so throughput is one element per cycle.
- Latency: accept edge to done=1 is vlen+2 cycles; total busy duration is vlen+2 cycles.
- alu_a and alu_b are 0 whenever no element is in the execute slot; alu_ctl holds the latched op.
- all_zero: set to 1 at accept, then ANDed with alu_zero on every element write.
- Aliasing: vd equal to vs1 or vs2 is legal. Element i is written after its own read, and later reads use different indices, so results equal the element-wise ALU result computed on the original source values.
- busy=1 in RUN, DRAIN and DONE.
- Assumption: the VRF returns the write of cycle k on any read issued in cycle k+1 or later.

Optional Feature:
- Macro: ALU_VEC_MASK_EN.
- Defined:
  - Adds input cmd_mask [ELEMS-1:0], latched at accept.
  - For element i with mask bit 0: wr_en=0 in its write cycle, and the element is excluded from all_zero.
  - Timing is unchanged; masked elements still occupy a cycle.
  - If all mask bits are 0, all_zero=1.
- Undefined: the port is absent and every element is written.

Test Plan:
- Reset: assert rst_n=0 mid-RUN with vlen=8 -> all outputs at reset values immediately; no done pulse; cmd_ready=1 after release.
- Add: ctl=0, vlen=4, vs1 elems {1,2,3,4}, vs2 {10,20,30,40} -> VRF writes {11,22,33,44} at idx 0..3 on consecutive cycles; done 6 cycles after accept; all_zero=0.
- Scalar subtract to zero: ctl=1, scalar_en=1, scalar=5, vs1 all 5, vlen=8 -> eight writes of 0; all_zero=1; cmd_ready low for 10 cycles.
- Zero length and clamping: vlen=0 -> done 1 cycle after accept, wr_en never asserted, all_zero=1. vlen=15 -> exactly 8 writes.
- Aliasing with back-to-back commands: vd=vs1, ctl=3 (lsl), vs1 {1,1,1,1}, b=scalar 4 -> {16,16,16,16}. A second command held valid during the first is accepted on the first IDLE cycle after done.
- Mask (ALU_VEC_MASK_EN defined): mask=8'b10100101, vlen=8 -> wr_en only at idx 0,2,5,7.

Source files
------------

// File: rtl/alu_vec_issue.sv
// alu_vec_issue: issue/sequencing stage for vector ALU commands.
//
// Accepts one command per valid/ready handshake, walks its elements through a
// two-stage read/execute pipeline (VRF read, then ALU + VRF write-back) at one
// element per cycle, and finishes with a one-cycle done pulse.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   cmd_valid / cmd_ready      command handshake; ready only while idle
//   cmd_ctl, cmd_vlen          ALU op code, element count (clamped to ELEMS)
//   cmd_vs1, cmd_vs2, cmd_vd   source/destination vector registers
//   cmd_scalar_en, cmd_scalar  optional scalar replacing operand b
//   cmd_mask                   per-element write enable (ALU_VEC_MASK_EN only)
//   rd_reg1/2, rd_idx          VRF read selects; rd_data1/2 arrive one cycle later
//   alu_ctl, alu_a, alu_b      ALU drive; alu_out, alu_zero come back combinationally
//   wr_en/reg/idx/data         VRF write-back
//   busy, done, all_zero       status; all_zero valid with done, held until next accept
//
// Optional feature: define ALU_VEC_MASK_EN to add the cmd_mask input.

module alu_vec_issue #(
    parameter int unsigned ELEMS = 8,
    parameter int unsigned AW    = 3,
    parameter int unsigned DW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [3:0]    cmd_ctl,
    input  logic [AW:0]   cmd_vlen,
    input  logic [4:0]    cmd_vs1,
    input  logic [4:0]    cmd_vs2,
    input  logic [4:0]    cmd_vd,
    input  logic          cmd_scalar_en,
    input  logic [DW-1:0] cmd_scalar,
`ifdef ALU_VEC_MASK_EN
    input  logic [ELEMS-1:0] cmd_mask,
`endif
    output logic [4:0]    rd_reg1,
    output logic [4:0]    rd_reg2,
    output logic [AW-1:0] rd_idx,
    input  logic [DW-1:0] rd_data1,
    input  logic [DW-1:0] rd_data2,
    output logic [3:0]    alu_ctl,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    input  logic [DW-1:0] alu_out,
    input  logic          alu_zero,
    output logic          wr_en,
    output logic [4:0]    wr_reg,
    output logic [AW-1:0] wr_idx,
    output logic [DW-1:0] wr_data,
    output logic          busy,
    output logic          done,
    output logic          all_zero
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    localparam logic [AW:0] VlenMax = (AW+1)'(ELEMS);

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [AW-1:0] last_q;
    logic          ex_valid_q, ex_valid_d;
    logic [AW-1:0] ex_idx_q, ex_idx_d;
    logic [3:0]    ctl_q;
    logic [4:0]    vs1_q, vs2_q, vd_q;
    logic          scalar_en_q;
    logic [DW-1:0] scalar_q;
    logic          all_zero_q;
    logic          accept;
    logic [AW:0]   vlen_c;
    logic [AW-1:0] last_d;
    logic          elem_en;

`ifdef ALU_VEC_MASK_EN
    logic [ELEMS-1:0] mask_q;
    assign elem_en = mask_q[ex_idx_q];
`else
    assign elem_en = 1'b1;
`endif

    assign cmd_ready = (state_q == StIdle);
    assign accept    = cmd_valid & cmd_ready;
    assign vlen_c    = (cmd_vlen > VlenMax) ? VlenMax : cmd_vlen;
    // Low AW bits of ELEMS are zero, so the wrap-around of the subtraction yields ELEMS-1.
    assign last_d    = vlen_c[AW-1:0] - AW'(1);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        ex_valid_d = 1'b0;
        ex_idx_d   = ex_idx_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    idx_d   = '0;
                    state_d = (vlen_c == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                // The read issued now executes and writes back next cycle.
                ex_valid_d = 1'b1;
                ex_idx_d   = idx_q;
                if (idx_q == last_q) begin
                    state_d = StDrain;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
            StDrain: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            ex_valid_q <= 1'b0;
            ex_idx_q   <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            ex_valid_q <= ex_valid_d;
            ex_idx_q   <= ex_idx_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q      <= '0;
            ctl_q       <= '0;
            vs1_q       <= '0;
            vs2_q       <= '0;
            vd_q        <= '0;
            scalar_en_q <= 1'b0;
            scalar_q    <= '0;
`ifdef ALU_VEC_MASK_EN
            mask_q      <= '0;
`endif
        end else if (accept) begin
            last_q      <= last_d;
            ctl_q       <= cmd_ctl;
            vs1_q       <= cmd_vs1;
            vs2_q       <= cmd_vs2;
            vd_q        <= cmd_vd;
            scalar_en_q <= cmd_scalar_en;
            scalar_q    <= cmd_scalar;
`ifdef ALU_VEC_MASK_EN
            mask_q      <= cmd_mask;
`endif
        end
    end

    // Starts true at accept; any written non-zero element clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            all_zero_q <= 1'b0;
        end else if (accept) begin
            all_zero_q <= 1'b1;
        end else if (ex_valid_q && elem_en) begin
            all_zero_q <= all_zero_q & alu_zero;
        end
    end

    assign rd_reg1  = vs1_q;
    assign rd_reg2  = vs2_q;
    assign rd_idx   = (state_q == StRun) ? idx_q : '0;

    assign alu_ctl  = ctl_q;
    assign alu_a    = ex_valid_q ? rd_data1 : '0;
    assign alu_b    = ex_valid_q ? (scalar_en_q ? scalar_q : rd_data2) : '0;

    assign wr_en    = ex_valid_q & elem_en;
    assign wr_reg   = vd_q;
    assign wr_idx   = ex_idx_q;
    assign wr_data  = ex_valid_q ? alu_out : '0;

    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StDone);
    assign all_zero = all_zero_q;

endmodule

// File: tb/tb_alu_vec_issue.sv
// Testbench for alu_vec_issue: bench-side VRF and ALU, a command-level model
// that predicts every write, busy window and done pulse, and directed vectors.
// Define ALU_VEC_MASK_EN to also exercise the masked-write path.

module tb_alu_vec_issue;

    localparam int ELEMS = 8;
    localparam int AW    = 3;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [3:0]    cmd_ctl = '0;
    logic [AW:0]   cmd_vlen = '0;
    logic [4:0]    cmd_vs1 = '0, cmd_vs2 = '0, cmd_vd = '0;
    logic          cmd_scalar_en = 1'b0;
    logic [DW-1:0] cmd_scalar = '0;
`ifdef ALU_VEC_MASK_EN
    logic [ELEMS-1:0] cmd_mask = '1;
`endif
    logic [4:0]    rd_reg1, rd_reg2;
    logic [AW-1:0] rd_idx;
    logic [DW-1:0] rd_data1 = '0, rd_data2 = '0;
    logic [3:0]    alu_ctl;
    logic [DW-1:0] alu_a, alu_b, alu_out;
    logic          alu_zero;
    logic          wr_en;
    logic [4:0]    wr_reg;
    logic [AW-1:0] wr_idx;
    logic [DW-1:0] wr_data;
    logic          busy, done, all_zero;

    always #5 clk = ~clk;

    alu_vec_issue #(.ELEMS(ELEMS), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ctl(cmd_ctl),
        .cmd_vlen(cmd_vlen), .cmd_vs1(cmd_vs1), .cmd_vs2(cmd_vs2), .cmd_vd(cmd_vd),
        .cmd_scalar_en(cmd_scalar_en), .cmd_scalar(cmd_scalar),
`ifdef ALU_VEC_MASK_EN
        .cmd_mask(cmd_mask),
`endif
        .rd_reg1(rd_reg1), .rd_reg2(rd_reg2), .rd_idx(rd_idx),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out), .alu_zero(alu_zero),
        .wr_en(wr_en), .wr_reg(wr_reg), .wr_idx(wr_idx), .wr_data(wr_data),
        .busy(busy), .done(done), .all_zero(all_zero)
    );

    // Bench ALU: 0 add, 1 sub, 2 and, 3 lsl, 4 or, 5 xor.
    function automatic logic [DW-1:0] alu_fn(input logic [3:0] c, input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
        case (c)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a << b[4:0];
            4'd4:    return a | b;
            4'd5:    return a ^ b;
            default: return '0;
        endcase
    endfunction

    assign alu_out  = alu_fn(alu_ctl, alu_a, alu_b);
    assign alu_zero = (alu_out == '0);

    // Bench VRF: synchronous read, write visible to reads issued next cycle.
    logic [DW-1:0] vrf [32][ELEMS];
    logic          pre_we = 1'b0;
    logic [4:0]    pre_reg = '0;
    logic [AW-1:0] pre_idx = '0;
    logic [DW-1:0] pre_data = '0;
    int            cyc = 0;

    always @(posedge clk) begin
        rd_data1 <= vrf[rd_reg1][rd_idx];
        rd_data2 <= vrf[rd_reg2][rd_idx];
        if (wr_en) vrf[wr_reg][wr_idx] <= wr_data;
        if (pre_we) vrf[pre_reg][pre_idx] <= pre_data;
        cyc <= cyc + 1;
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cycle %0d: actual %0d, required %0d", nm, cyc, act, exp);
        end
    endtask

    // Command-level model state.
    typedef struct packed {
        logic          en;
        logic [4:0]    r;
        logic [AW-1:0] i;
        logic [DW-1:0] d;
    } wr_t;

    wr_t           exp_w [int];
    logic [DW-1:0] ref_vrf [32][ELEMS];
    int            busy_from = 0, busy_to = -1, done_cyc = -1;
    logic          exp_az = 1'b0;
    int            acc_cyc = 0, done_seen = -1, n_writes = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (pre_we) ref_vrf[pre_reg][pre_idx] = pre_data;
            if (!rst_n) begin
                chk("rst_busy", 32'(busy), 0);
                chk("rst_done", 32'(done), 0);
                chk("rst_wr_en", 32'(wr_en), 0);
                chk("rst_ready", 32'(cmd_ready), 1);
                chk("rst_all_zero", 32'(all_zero), 0);
                chk("rst_rd_idx", 32'(rd_idx), 0);
                chk("rst_rd_reg1", 32'(rd_reg1), 0);
                chk("rst_alu_a", alu_a, 0);
                chk("rst_wr_data", wr_data, 0);
                exp_w.delete();
                busy_to  = -1;
                done_cyc = -1;
            end else begin
                logic eb;
                eb = (cyc >= busy_from) && (cyc <= busy_to);
                chk("cmd_ready", 32'(cmd_ready), 32'(!eb));
                chk("busy", 32'(busy), 32'(eb));
                chk("done", 32'(done), 32'(cyc == done_cyc));
                if (cyc == done_cyc) chk("all_zero", 32'(all_zero), 32'(exp_az));
                if (done === 1'b1) done_seen = cyc;
                if (wr_en === 1'b1) n_writes++;
                if (exp_w.exists(cyc)) begin
                    chk("wr_en", 32'(wr_en), 32'(exp_w[cyc].en));
                    if (exp_w[cyc].en) begin
                        chk("wr_reg", 32'(wr_reg), 32'(exp_w[cyc].r));
                        chk("wr_idx", 32'(wr_idx), 32'(exp_w[cyc].i));
                        chk("wr_data", wr_data, exp_w[cyc].d);
                    end
                    exp_w.delete(cyc);
                end else begin
                    chk("wr_en_idle", 32'(wr_en), 0);
                    chk("alu_a_idle", alu_a, 0);
                    chk("alu_b_idle", alu_b, 0);
                end
                // Accept happens at the coming edge when valid is offered and the
                // model says the block is idle.
                if (cmd_valid && !eb) begin
                    int            vl;
                    logic          az;
                    logic [7:0]    mk;
                    logic [DW-1:0] res [ELEMS];
                    logic [DW-1:0] b;
                    vl = (int'(cmd_vlen) > ELEMS) ? ELEMS : int'(cmd_vlen);
`ifdef ALU_VEC_MASK_EN
                    mk = cmd_mask;
`else
                    mk = 8'hFF;
`endif
                    az = 1'b1;
                    for (int i = 0; i < vl; i++) begin
                        b = cmd_scalar_en ? cmd_scalar : ref_vrf[cmd_vs2][i];
                        res[i] = alu_fn(cmd_ctl, ref_vrf[cmd_vs1][i], b);
                        exp_w[cyc + 2 + i] = '{mk[i], cmd_vd, AW'(i), res[i]};
                        if (mk[i]) az = az & (res[i] == '0);
                    end
                    for (int i = 0; i < vl; i++) begin
                        if (mk[i]) ref_vrf[cmd_vd][i] = res[i];
                    end
                    exp_az    = az;
                    acc_cyc   = cyc;
                    busy_from = cyc + 1;
                    done_cyc  = (vl == 0) ? cyc + 1 : cyc + vl + 2;
                    busy_to   = done_cyc;
                end
            end
        end
    end

    task automatic preload(input int r, input int i, input logic [DW-1:0] d);
        pre_we   = 1'b1;
        pre_reg  = 5'(r);
        pre_idx  = AW'(i);
        pre_data = d;
        @(posedge clk); #1;
        pre_we   = 1'b0;
    endtask

    task automatic run_cmd(input int ctl, input int vlen, input int vs1, input int vs2,
                           input int vd, input logic sen, input logic [DW-1:0] sc,
                           input logic [7:0] mk);
        bit got;
        @(posedge clk); #1;
        cmd_valid     = 1'b1;
        cmd_ctl       = 4'(ctl);
        cmd_vlen      = (AW+1)'(vlen);
        cmd_vs1       = 5'(vs1);
        cmd_vs2       = 5'(vs2);
        cmd_vd        = 5'(vd);
        cmd_scalar_en = sen;
        cmd_scalar    = sc;
`ifdef ALU_VEC_MASK_EN
        cmd_mask      = mk;
`else
        if (mk == 8'h00) cmd_scalar = sc;
`endif
        got = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (cmd_ready === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: cmd_ready never rose, required 1");
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(output int dc);
        dc = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dc = cyc;
                break;
            end
        end
        if (dc < 0) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout: done never pulsed, required 1");
        end
    endtask

    initial begin
        int dc, nw0, done_a;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_reset", 32'(cmd_ready), 1);

        for (int i = 0; i < ELEMS; i++) begin
            preload(1, i, DW'(i + 1));
            preload(2, i, DW'(10 * (i + 1)));
            preload(4, i, 32'd5);
            preload(7, i, 32'd1);
        end

        // Add, vlen 4
        run_cmd(0, 4, 1, 2, 3, 1'b0, 0, 8'hFF);
        wait_done(dc);
        chk("add_latency", 32'(dc - acc_cyc), 6);
        chk("add_all_zero", 32'(all_zero), 0);
        chk("add_v0", vrf[3][0], 32'd11);
        chk("add_v1", vrf[3][1], 32'd22);
        chk("add_v2", vrf[3][2], 32'd33);
        chk("add_v3", vrf[3][3], 32'd44);

        // Scalar subtract to zero, vlen 8
        nw0 = n_writes;
        run_cmd(1, 8, 4, 0, 5, 1'b1, 32'd5, 8'hFF);
        wait_done(dc);
        chk("sub_latency", 32'(dc - acc_cyc), 10);
        chk("sub_all_zero", 32'(all_zero), 1);
        chk("sub_writes", 32'(n_writes - nw0), 8);
        chk("sub_v7", vrf[5][7], 32'd0);

        // Zero length
        nw0 = n_writes;
        run_cmd(0, 0, 1, 2, 10, 1'b0, 0, 8'hFF);
        wait_done(dc);
        chk("vlen0_latency", 32'(dc - acc_cyc), 1);
        chk("vlen0_all_zero", 32'(all_zero), 1);
        chk("vlen0_writes", 32'(n_writes - nw0), 0);

        // Clamp 15 -> 8
        nw0 = n_writes;
        run_cmd(0, 15, 1, 2, 11, 1'b0, 0, 8'hFF);
        wait_done(dc);
        chk("clamp_latency", 32'(dc - acc_cyc), 10);
        chk("clamp_writes", 32'(n_writes - nw0), 8);
        chk("clamp_v7", vrf[11][7], 32'd88);

        // Aliased lsl, then a second command held valid during the first
        run_cmd(3, 4, 7, 0, 7, 1'b1, 32'd4, 8'hFF);
        run_cmd(0, 4, 7, 7, 8, 1'b0, 0, 8'hFF);
        done_a = done_seen;
        chk("b2b_accept", 32'(acc_cyc - done_a), 1);
        wait_done(dc);
        for (int i = 0; i < 4; i++) begin
            chk("alias_v7", vrf[7][i], 32'd16);
            chk("b2b_v8", vrf[8][i], 32'd32);
        end
        chk("alias_v7_untouched", vrf[7][4], 32'd1);

`ifdef ALU_VEC_MASK_EN
        nw0 = n_writes;
        run_cmd(0, 8, 1, 2, 12, 1'b0, 0, 8'b1010_0101);
        wait_done(dc);
        chk("mask_writes", 32'(n_writes - nw0), 4);
        chk("mask_v5", vrf[12][5], 32'd66);
`endif

        // Reset mid-run, vlen 8
        run_cmd(0, 8, 1, 2, 9, 1'b0, 0, 8'hFF);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_wr_en", 32'(wr_en), 0);
        chk("midrst_ready", 32'(cmd_ready), 1);
        chk("midrst_done", 32'(done), 0);
        nw0 = n_writes;
        dc = done_seen;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("midrst_no_writes", 32'(n_writes - nw0), 0);
        chk("midrst_no_done", 32'(done_seen - dc), 0);
        chk("midrst_ready_after", 32'(cmd_ready), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
